friscv_fetch: RTL and testbench
===============================

FRISCV_FETCH -- requirements
Module: friscv_fetch

Interface
REQ-001 Parameter ARCH, default 32: instruction/address width in bits.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 Parameter FIFO_DEPTH, default 4: instruction buffer entries; power of 2, >= 2.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid_out  output  1  fetch request valid to instruction memory.
REQ-007 req_ready_in  input  1  memory accepts request this cycle.
REQ-008 req_addr_out  output  ARCH  byte address of request, bits [1:0] always 0.
REQ-009 rsp_valid_in  input  1  in-order response valid; no backpressure.
REQ-010 rsp_data_in  input  ARCH  fetched instruction word.
REQ-011 instr_valid_out  output  1  buffered instruction available to decode.
REQ-012 instr_ready_in  input  1  decode consumes instruction this cycle.
REQ-013 instr_data_out  output  ARCH  instruction word at FIFO head.
REQ-014 instr_pc_out  output  ARCH  address of instruction at FIFO head.
REQ-015 redirect_valid_in  input  1  branch/jump redirect request.
REQ-016 redirect_pc_in  input  ARCH  redirect target.
REQ-017 halt_in  input  1  stop issuing new requests while high.
REQ-018 misalign_out  output  1  one-cycle pulse: redirect target had bits [1:0] != 0.

Function
REQ-019 Request handshake completes when req_valid_out & req_ready_in; fetch PC then advances by 4, wrapping modulo 2^ARCH.
REQ-020 req_valid_out SHALL be high only in FETCH state, halt_in low, no redirect this cycle, and (fifo_count + outstanding) < FIFO_DEPTH.
REQ-021 Credit check uses registered counts only; a same-cycle instr pop frees no credit.
REQ-022 req_valid_out, once high, SHALL hold req_addr_out stable until handshake or redirect.
REQ-023 Outstanding counter, width $clog2(FIFO_DEPTH+1): +1 per request handshake, -1 per rsp_valid_in, both same cycle = unchanged.
REQ-024 In FETCH, each response pushes {rsp_data_in, its request address} into FIFO; instr_valid_out rises the following cycle (1-cycle response-to-output latency).
REQ-025 Instr handshake completes when instr_valid_out & instr_ready_in; pops head; simultaneous push and pop on a non-empty FIFO keeps count.
REQ-026 FIFO SHALL never overflow; response arriving with FIFO full is a protocol violation (assertion).
REQ-027 States: FETCH, FLUSH, HALTED.
REQ-028 FETCH -> HALTED when halt_in high and outstanding (after this cycle) = 0; HALTED -> FETCH when halt_in low.
REQ-029 Redirect in any state: FIFO cleared, fetch PC <= {redirect_pc_in[ARCH-1:2], 2'b00}, no request issued that cycle.
REQ-030 Redirect with post-cycle outstanding > 0 -> FLUSH; otherwise -> FETCH (HALTED if halt_in high).
REQ-031 FLUSH: no requests; all responses discarded; -> FETCH (or HALTED if halt_in) when outstanding reaches 0.
REQ-032 Redirect during FLUSH: update PC, remain in FLUSH.
REQ-033 Redirect coincident with instr pop: redirect wins; popped instruction is still the one decoded, FIFO then empty.
REQ-034 Redirect coincident with request handshake: that request counts outstanding and its response is discarded.
REQ-035 misalign_out pulses the cycle after a redirect with redirect_pc_in[1:0] != 0.

Reset
REQ-036 rst high: state FETCH, fetch PC = RESET_PC, FIFO empty, outstanding = 0.
REQ-037 During reset: req_valid_out = 0, instr_valid_out = 0, misalign_out = 0, instr_data_out = 0, instr_pc_out = 0.
REQ-038 Reset mid-operation discards all buffered and in-flight state; responses from pre-reset requests arriving after reset are the memory's responsibility to suppress.
REQ-039 First request (addr RESET_PC) asserted in first cycle with rst low.

Structure
REQ-040 fetch_state_t enum and FETCH_FIFO_DEPTH default constant live in friscv_pkg; ARCH taken from friscv_pkg.
REQ-041 Buffer implemented as sub-module friscv_fifo: synchronous, parametrised width/depth, sync flush input, count output.

Verification
REQ-042 Reset, req_ready_in=1, 1-cycle memory -> requests 0x0,0x4,0x8,0xC; instr_pc_out sequence 0x0,0x4,... matching data.
REQ-043 instr_ready_in=0, DEPTH=4 -> exactly 4 requests issued, req_valid_out low thereafter; one pop -> one further request.
REQ-044 Redirect to 0x100 with 2 outstanding -> FLUSH, both responses dropped, next request 0x100, first instr_pc_out 0x100.
REQ-045 Redirect to 0x202 -> misalign_out pulse one cycle, next request addr 0x200.
REQ-046 halt_in high with 1 outstanding -> response buffered, HALTED, no requests; halt_in low -> requests resume at next PC.
REQ-047 Fetch PC 0xFFFF_FFFC handshake -> next req_addr_out 0x0000_0000; rst mid-stream -> outputs 0, next request RESET_PC.

Source files
------------

// File: rtl/friscv_pkg.sv
// ==== friscv_pkg : shared fetch-unit types and defaults | rev 1.0 ====
`default_nettype none

package friscv_pkg;

  localparam int FRISCV_ARCH      = 32;
  localparam int FETCH_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    FLUSH  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/friscv_fifo.sv
// ==== friscv_fifo : synchronous FIFO with sync flush and occupancy count | rev 1.0 ====
`default_nettype none

module friscv_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign empty    = (cnt == '0);
  assign full     = (cnt == CW'(DEPTH));
  assign count    = cnt;
  assign pop_data = mem[rd_ptr];
  assign do_pop   = pop && !empty;
  // A push into a full buffer is only legal when the head leaves the same cycle.
  assign do_push  = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      assert (!(push && full && !pop));
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

`default_nettype wire

// File: rtl/friscv_fetch.sv
// ==== friscv_fetch : credit-limited instruction fetch with redirect/flush/halt | rev 1.0 ====
`default_nettype none

module friscv_fetch
  import friscv_pkg::*;
#(
  parameter int              ARCH       = FRISCV_ARCH,
  parameter logic [ARCH-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = FETCH_FIFO_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  output logic            req_valid_out,
  input  logic            req_ready_in,
  output logic [ARCH-1:0] req_addr_out,
  input  logic            rsp_valid_in,
  input  logic [ARCH-1:0] rsp_data_in,
  output logic            instr_valid_out,
  input  logic            instr_ready_in,
  output logic [ARCH-1:0] instr_data_out,
  output logic [ARCH-1:0] instr_pc_out,
  input  logic            redirect_valid_in,
  input  logic [ARCH-1:0] redirect_pc_in,
  input  logic            halt_in,
  output logic            misalign_out
);

  localparam int CW = $clog2(FIFO_DEPTH+1);

  fetch_state_t      state;
  fetch_state_t      state_next;
  logic [ARCH-1:0]   pc;
  logic [ARCH-1:0]   pc_next;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     outstanding_next;
  logic              misalign_q;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic [2*ARCH-1:0] fifo_head;
  logic [CW:0]       credit_used;
  logic              req_fire;
  logic              rsp_push;
  logic              instr_pop;
  logic [ARCH-1:0]   rsp_addr;

  assign credit_used   = {1'b0, fifo_count} + {1'b0, outstanding};
  assign req_valid_out = !rst && (state == FETCH) && !halt_in && !redirect_valid_in &&
                         (credit_used < (CW+1)'(FIFO_DEPTH));
  assign req_addr_out  = pc;
  assign req_fire      = req_valid_out && req_ready_in;

  assign outstanding_next = outstanding + CW'(req_fire) - CW'(rsp_valid_in);

  // Responses are in order and contiguous, so the oldest in-flight address is
  // the fetch PC minus four bytes per outstanding request.
  assign rsp_addr = pc - ARCH'({outstanding, 2'b00});
  assign rsp_push = rsp_valid_in && (state == FETCH) && !redirect_valid_in;

  assign instr_valid_out = !rst && !fifo_empty;
  assign instr_pop       = instr_valid_out && instr_ready_in;
  assign instr_data_out  = rst ? '0 : fifo_head[2*ARCH-1:ARCH];
  assign instr_pc_out    = rst ? '0 : fifo_head[ARCH-1:0];
  assign misalign_out    = !rst && misalign_q;

  friscv_fifo #(
    .WIDTH (2*ARCH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid_in),
    .push      (rsp_push),
    .push_data ({rsp_data_in, rsp_addr}),
    .pop       (instr_pop),
    .pop_data  (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  always_comb begin
    state_next = state;
    pc_next    = pc;
    if (req_fire) begin
      pc_next = pc + ARCH'(4);
    end
    if (redirect_valid_in) begin
      pc_next = {redirect_pc_in[ARCH-1:2], 2'b00};
      if (outstanding_next != '0) begin
        state_next = FLUSH;
      end else begin
        state_next = halt_in ? HALTED : FETCH;
      end
    end else begin
      case (state)
        FETCH:   if (halt_in && (outstanding_next == '0)) state_next = HALTED;
        FLUSH:   if (outstanding_next == '0) state_next = halt_in ? HALTED : FETCH;
        HALTED:  if (!halt_in) state_next = FETCH;
        default: state_next = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      outstanding <= '0;
      misalign_q  <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      outstanding <= outstanding_next;
      misalign_q  <= redirect_valid_in && (redirect_pc_in[1:0] != 2'b00);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_friscv_fetch.sv
// ==== tb_friscv_fetch : directed self-checking bench for friscv_fetch | rev 1.0 ====
`default_nettype none

module tb_friscv_fetch;

  logic        clk;
  logic        rst;
  logic        req_valid_out;
  logic        req_ready_in;
  logic [31:0] req_addr_out;
  logic        rsp_valid_in;
  logic [31:0] rsp_data_in;
  logic        instr_valid_out;
  logic        instr_ready_in;
  logic [31:0] instr_data_out;
  logic [31:0] instr_pc_out;
  logic        redirect_valid_in;
  logic [31:0] redirect_pc_in;
  logic        halt_in;
  logic        misalign_out;

  logic        mem_hold;
  logic        mem_clear;
  logic        hs;
  logic [31:0] ha;
  logic [31:0] q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  friscv_fetch dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid_out     (req_valid_out),
    .req_ready_in      (req_ready_in),
    .req_addr_out      (req_addr_out),
    .rsp_valid_in      (rsp_valid_in),
    .rsp_data_in       (rsp_data_in),
    .instr_valid_out   (instr_valid_out),
    .instr_ready_in    (instr_ready_in),
    .instr_data_out    (instr_data_out),
    .instr_pc_out      (instr_pc_out),
    .redirect_valid_in (redirect_valid_in),
    .redirect_pc_in    (redirect_pc_in),
    .halt_in           (halt_in),
    .misalign_out      (misalign_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mk(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One-cycle in-order memory; mem_hold parks responses, mem_clear drops them.
  initial begin
    rsp_valid_in = 1'b0;
    rsp_data_in  = '0;
    forever begin
      @(negedge clk);
      hs = req_valid_out && req_ready_in;
      ha = req_addr_out;
      @(posedge clk);
      #2;
      if (hs) q.push_back(ha);
      if (mem_clear) begin
        q.delete();
        rsp_valid_in = 1'b0;
      end else if (!mem_hold && q.size() > 0) begin
        rsp_valid_in = 1'b1;
        rsp_data_in  = mk(q.pop_front());
      end else begin
        rsp_valid_in = 1'b0;
      end
    end
  end

  initial begin
    rst = 1'b1; req_ready_in = 1'b1; instr_ready_in = 1'b0; halt_in = 1'b0;
    redirect_valid_in = 1'b0; redirect_pc_in = '0; mem_hold = 1'b0; mem_clear = 1'b0;

    @(negedge clk);
    check("rst_req_valid", 32'(req_valid_out), 32'd0);
    check("rst_instr_valid", 32'(instr_valid_out), 32'd0);
    check("rst_misalign", 32'(misalign_out), 32'd0);
    check("rst_instr_data", instr_data_out, 32'd0);
    check("rst_instr_pc", instr_pc_out, 32'd0);

    // Streaming fetch with decode stalled: four requests fill the credits.
    tick(); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      @(negedge clk);
      check("stream_req_valid", 32'(req_valid_out), 32'd1);
      check("stream_req_addr", req_addr_out, 32'(4 * i));
      if (i == 2) begin
        check("first_instr_valid", 32'(instr_valid_out), 32'd1);
        check("first_instr_pc", instr_pc_out, 32'h0);
        check("first_instr_data", instr_data_out, mk(32'h0));
      end
    end
    tick(); @(negedge clk);
    check("credit_stop_a", 32'(req_valid_out), 32'd0);
    tick(); @(negedge clk);
    check("credit_stop_b", 32'(req_valid_out), 32'd0);
    tick(); instr_ready_in = 1'b1; @(negedge clk);
    check("pop_head_pc", instr_pc_out, 32'h0);
    check("pop_no_same_cycle_credit", 32'(req_valid_out), 32'd0);
    tick(); instr_ready_in = 1'b0; @(negedge clk);
    check("credit_refill_valid", 32'(req_valid_out), 32'd1);
    check("credit_refill_addr", req_addr_out, 32'h10);
    check("head_after_pop", instr_pc_out, 32'h4);
    tick(); @(negedge clk);
    check("credit_stop_c", 32'(req_valid_out), 32'd0);
    tick(); @(negedge clk);
    check("credit_stop_d", 32'(req_valid_out), 32'd0);

    // Drain in order with memory requests blocked.
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) begin req_ready_in = 1'b0; instr_ready_in = 1'b1; end
      @(negedge clk);
      check("drain_pc", instr_pc_out, 32'(4 + 4 * i));
      check("drain_data", instr_data_out, mk(32'(4 + 4 * i)));
    end
    tick(); instr_ready_in = 1'b0; mem_hold = 1'b1; @(negedge clk);
    check("drained_empty", 32'(instr_valid_out), 32'd0);

    // Two requests in flight, then redirect to 0x100.
    tick(); req_ready_in = 1'b1; @(negedge clk);
    check("flush_setup_a", req_addr_out, 32'h14);
    tick(); @(negedge clk);
    check("flush_setup_b", req_addr_out, 32'h18);
    tick(); redirect_valid_in = 1'b1; redirect_pc_in = 32'h100; @(negedge clk);
    check("redirect_blocks_req", 32'(req_valid_out), 32'd0);
    tick(); redirect_valid_in = 1'b0; mem_hold = 1'b0; @(negedge clk);
    check("flush_no_req_a", 32'(req_valid_out), 32'd0);
    tick(); @(negedge clk);
    check("flush_no_req_b", 32'(req_valid_out), 32'd0);
    check("flush_dropped", 32'(instr_valid_out), 32'd0);
    tick(); @(negedge clk);
    check("after_flush_valid", 32'(req_valid_out), 32'd1);
    check("after_flush_addr", req_addr_out, 32'h100);
    check("after_flush_empty", 32'(instr_valid_out), 32'd0);
    tick();
    tick(); req_ready_in = 1'b0; @(negedge clk);
    check("redir_instr_valid", 32'(instr_valid_out), 32'd1);
    check("redir_instr_pc", instr_pc_out, 32'h100);
    check("redir_instr_data", instr_data_out, mk(32'h100));

    // Misaligned redirect coincident with a pop.
    tick(); redirect_valid_in = 1'b1; redirect_pc_in = 32'h202; instr_ready_in = 1'b1; @(negedge clk);
    check("pop_with_redirect_pc", instr_pc_out, 32'h100);
    check("misalign_not_yet", 32'(misalign_out), 32'd0);
    tick(); redirect_valid_in = 1'b0; instr_ready_in = 1'b0; @(negedge clk);
    check("misalign_pulse", 32'(misalign_out), 32'd1);
    check("aligned_req_valid", 32'(req_valid_out), 32'd1);
    check("aligned_req_addr", req_addr_out, 32'h200);
    check("fifo_cleared", 32'(instr_valid_out), 32'd0);
    tick(); req_ready_in = 1'b1; @(negedge clk);
    check("misalign_one_cycle", 32'(misalign_out), 32'd0);

    // Halt with one request outstanding.
    tick(); halt_in = 1'b1; @(negedge clk);
    check("halt_no_req", 32'(req_valid_out), 32'd0);
    tick(); @(negedge clk);
    check("halted_no_req", 32'(req_valid_out), 32'd0);
    check("halt_buffered_valid", 32'(instr_valid_out), 32'd1);
    check("halt_buffered_pc", instr_pc_out, 32'h200);
    tick(); @(negedge clk);
    check("halted_still", 32'(req_valid_out), 32'd0);
    tick(); halt_in = 1'b0; @(negedge clk);
    check("unhalt_first_cycle", 32'(req_valid_out), 32'd0);
    tick(); req_ready_in = 1'b0; instr_ready_in = 1'b1; @(negedge clk);
    check("resume_valid", 32'(req_valid_out), 32'd1);
    check("resume_addr", req_addr_out, 32'h204);
    check("resume_head_pc", instr_pc_out, 32'h200);

    // Address wrap at the top of the space.
    tick(); instr_ready_in = 1'b0; redirect_valid_in = 1'b1; redirect_pc_in = 32'hFFFF_FFFC;
    req_ready_in = 1'b1; @(negedge clk);
    check("wrap_setup_empty", 32'(instr_valid_out), 32'd0);
    tick(); redirect_valid_in = 1'b0; @(negedge clk);
    check("aligned_no_misalign", 32'(misalign_out), 32'd0);
    check("wrap_top_addr", req_addr_out, 32'hFFFF_FFFC);
    tick(); @(negedge clk);
    check("wrap_valid", 32'(req_valid_out), 32'd1);
    check("wrap_addr", req_addr_out, 32'h0);
    tick(); @(negedge clk);
    check("wrap_instr_pc", instr_pc_out, 32'hFFFF_FFFC);
    check("wrap_instr_data", instr_data_out, mk(32'hFFFF_FFFC));
    check("wrap_next_addr", req_addr_out, 32'h4);

    // Reset mid-stream.
    tick(); rst = 1'b1; mem_clear = 1'b1; @(negedge clk);
    check("mid_rst_req_valid", 32'(req_valid_out), 32'd0);
    check("mid_rst_instr_valid", 32'(instr_valid_out), 32'd0);
    check("mid_rst_misalign", 32'(misalign_out), 32'd0);
    check("mid_rst_instr_data", instr_data_out, 32'd0);
    check("mid_rst_instr_pc", instr_pc_out, 32'd0);
    tick(); rst = 1'b0; @(negedge clk);
    check("post_rst_valid", 32'(req_valid_out), 32'd1);
    check("post_rst_addr", req_addr_out, 32'h0);
    check("post_rst_empty", 32'(instr_valid_out), 32'd0);
    tick(); mem_clear = 1'b0; @(negedge clk);
    check("post_rst_addr2", req_addr_out, 32'h4);
    tick(); @(negedge clk);
    check("post_rst_instr_valid", 32'(instr_valid_out), 32'd1);
    check("post_rst_instr_pc", instr_pc_out, 32'h0);
    check("post_rst_instr_data", instr_data_out, mk(32'h0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
